// File: rtl/act_pingpong_bank_if.sv
// Handshake/bus bundle for the double-buffered activation store.
// The producer fills rows and the junction side reads interleaved lanes.
interface act_pingpong_bank_if #(
  parameter int unsigned p  = 32,
  parameter int unsigned z  = 8,
  parameter int unsigned bw = 16
);
  localparam int unsigned log_pbyz = (p == z) ? 1 : $clog2(p / z);
  localparam int unsigned log_p    = $clog2(p);

  logic                  wr_en;
  logic [log_pbyz-1:0]   wr_addr;
  logic [bw*z-1:0]       wr_data;
  logic                  wr_done;
  logic                  wr_ready;
  logic                  rd_en;
  logic [log_p*z-1:0]    memory_index_package;
  logic                  rd_done;
  logic                  rd_ready;
  logic [bw*z-1:0]       rd_data;
  logic                  rd_valid;
  logic                  lane_err;
  logic                  wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_en, memory_index_package, rd_done,
    input  wr_ready, rd_ready, rd_data, rd_valid, lane_err, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_en, memory_index_package, rd_done,
    output wr_ready, rd_ready, rd_data, rd_valid, lane_err, wr_drop
  );
endinterface

// File: rtl/act_pingpong_bank.sv
// Ping-pong activation store: z single-read banks per buffer, two buffers.
// One buffer is filled row by row while the other serves interleaved lane reads.
module act_pingpong_bank #(
  parameter int unsigned p  = 32,
  parameter int unsigned z  = 8,
  parameter int unsigned bw = 16
) (
  input logic               clk,
  input logic               reset_n,
  act_pingpong_bank_if.slave bus
);
  localparam int unsigned log_pbyz = (p == z) ? 1 : $clog2(p / z);
  localparam int unsigned log_p    = $clog2(p);
  localparam int unsigned log_z    = $clog2(z);
  localparam int unsigned rows     = 1 << log_pbyz;

  logic [bw-1:0] mem [2][z][rows];

  logic                         wsel;
  logic                         rsel;
  logic [1:0]                   full_cnt;
  logic [bw*z-1:0]              rd_data_q;
  logic                         rd_valid_q;
  logic                         lane_err_q;
  logic                         wr_drop_q;

  logic                         wr_ready_c;
  logic                         rd_ready_c;
  logic                         wr_ok_c;
  logic                         rd_ok_c;
  logic                         wr_hand_c;
  logic                         rd_rel_c;
  logic [log_pbyz-1:0]          wr_row_c;
  logic [z-1:0][log_pbyz-1:0]   rd_row_c;
  logic [z-1:0][bw-1:0]         rd_word_c;
  logic [z-1:0]                 lane_bad_c;

  // Buffer status is a pure function of full_cnt; no input reaches these outputs.
  assign wr_ready_c = (full_cnt < 2'd2);
  assign rd_ready_c = (full_cnt != 2'd0);
  assign wr_ok_c    = bus.wr_en   && wr_ready_c;
  assign rd_ok_c    = bus.rd_en   && rd_ready_c;
  assign wr_hand_c  = bus.wr_done && wr_ready_c;
  assign rd_rel_c   = bus.rd_done && rd_ready_c;

  assign bus.wr_ready = wr_ready_c;
  assign bus.rd_ready = rd_ready_c;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.lane_err = lane_err_q;
  assign bus.wr_drop  = wr_drop_q;

  if (p == z) begin : g_wr_flat
    logic unused_wr_addr;
    assign unused_wr_addr = ^bus.wr_addr;
    assign wr_row_c       = '0;
  end else begin : g_wr_row
    assign wr_row_c = bus.wr_addr;
  end

  // Lane i always reads bank i; the index only picks the row and is checked for its bank.
  for (genvar i = 0; i < z; i++) begin : g_lane
    logic [log_p-1:0] idx;
    assign idx = bus.memory_index_package[log_p*i +: log_p];

    if (p == z) begin : g_row_flat
      assign rd_row_c[i] = '0;
    end else begin : g_row_sel
      assign rd_row_c[i] = idx[log_p-1 -: log_pbyz];
    end

    if (z > 1) begin : g_chk
      assign lane_bad_c[i] = (idx[log_z-1:0] != log_z'(i));
    end else begin : g_nochk
      assign lane_bad_c[i] = 1'b0;
    end

    assign rd_word_c[i] = mem[rsel][i][rd_row_c[i]];
  end

  // Bank storage carries no reset; stale data stays unreadable until a buffer is handed over.
  always_ff @(posedge clk) begin : p_mem
    if (wr_ok_c) begin
      for (int i = 0; i < int'(z); i++) begin
        mem[wsel][i][wr_row_c] <= bus.wr_data[bw*i +: bw];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_ctrl
    if (!reset_n) begin
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      full_cnt   <= 2'd0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      lane_err_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      if (wr_hand_c) wsel <= ~wsel;
      if (rd_rel_c)  rsel <= ~rsel;
      full_cnt   <= full_cnt + 2'(wr_hand_c) - 2'(rd_rel_c);
      rd_valid_q <= rd_ok_c;
      if (rd_ok_c) rd_data_q <= rd_word_c;
      if (bus.rd_en && (|lane_bad_c)) lane_err_q <= 1'b1;
      if (!wr_ready_c && (bus.wr_en || bus.wr_done)) wr_drop_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_act_pingpong_bank.sv
// Randomized and directed checks of act_pingpong_bank against a neuron-indexed buffer model.
module tb_act_pingpong_bank;
  localparam int unsigned P  = 32;
  localparam int unsigned Z  = 8;
  localparam int unsigned BW = 16;
  localparam int unsigned LP = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  act_pingpong_bank_if #(.p(P), .z(Z), .bw(BW)) bus ();
  act_pingpong_bank #(.p(P), .z(Z), .bw(BW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: two buffers addressed by neuron number, plus a count of full buffers.
  logic [BW-1:0]   m_buf [2][P];
  int              m_wb, m_rb, m_cnt;
  logic [BW*Z-1:0] m_rd_data;
  logic            m_rd_valid, m_err, m_drop;
  int              ix [Z];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LP*Z-1:0] pack_ix();
    logic [LP*Z-1:0] v;
    for (int i = 0; i < int'(Z); i++) v[LP*i +: LP] = LP'(ix[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_wb = 0; m_rb = 0; m_cnt = 0;
    m_rd_data = '0; m_rd_valid = 1'b0; m_err = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_edge();
    bit wr_rdy, rd_rdy;
    int idx, n;
    wr_rdy = (m_cnt < 2);
    rd_rdy = (m_cnt > 0);
    if (bus.rd_en) begin
      for (int i = 0; i < int'(Z); i++) begin
        idx = int'(bus.memory_index_package[LP*i +: LP]);
        if ((idx % Z) != i) m_err = 1'b1;
      end
    end
    if (bus.rd_en && rd_rdy) begin
      for (int i = 0; i < int'(Z); i++) begin
        idx = int'(bus.memory_index_package[LP*i +: LP]);
        n = (idx / Z) * Z + i;
        m_rd_data[BW*i +: BW] = m_buf[m_rb][n];
      end
      m_rd_valid = 1'b1;
    end else begin
      m_rd_valid = 1'b0;
    end
    if (bus.wr_en && wr_rdy)
      for (int i = 0; i < int'(Z); i++)
        m_buf[m_wb][int'(bus.wr_addr) * Z + i] = bus.wr_data[BW*i +: BW];
    if (!wr_rdy && (bus.wr_en || bus.wr_done)) m_drop = 1'b1;
    if (bus.wr_done && wr_rdy) begin m_wb = 1 - m_wb; m_cnt++; end
    if (bus.rd_done && rd_rdy) begin m_rb = 1 - m_rb; m_cnt--; end
  endtask

  task automatic check_outputs();
    check("wr_ready", 128'(bus.wr_ready), 128'(m_cnt < 2));
    check("rd_ready", 128'(bus.rd_ready), 128'(m_cnt > 0));
    check("rd_valid", 128'(bus.rd_valid), 128'(m_rd_valid));
    check("rd_data",  128'(bus.rd_data),  128'(m_rd_data));
    check("lane_err", 128'(bus.lane_err), 128'(m_err));
    check("wr_drop",  128'(bus.wr_drop),  128'(m_drop));
  endtask

  // Drives one cycle of inputs, advances the model at the edge, checks #1 later.
  task automatic cycle(input bit we, input int wa, input logic [BW*Z-1:0] wd, input bit wdn,
                       input bit re, input logic [LP*Z-1:0] mip, input bit rdn);
    bus.wr_en = we; bus.wr_addr = 2'(wa); bus.wr_data = wd; bus.wr_done = wdn;
    bus.rd_en = re; bus.memory_index_package = mip; bus.rd_done = rdn;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_done = 1'b0;
    bus.rd_en = 1'b0; bus.memory_index_package = '0; bus.rd_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
  endtask

  task automatic fill(input logic [BW-1:0] base);
    logic [BW*Z-1:0] wd;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(Z); i++) wd[BW*i +: BW] = base + BW'(r * Z + i);
      cycle(1'b1, r, wd, 1'b0, 1'b0, '0, 1'b0);
    end
    cycle(1'b0, 0, '0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic set_ix_identity();
    for (int i = 0; i < int'(Z); i++) ix[i] = i;
  endtask

  logic [BW*Z-1:0] exp_v;
  logic [LP*Z-1:0] mip;
  logic [BW*Z-1:0] wd;
  int              exp_lanes [Z];

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    check("rst_wr_ready", 128'(bus.wr_ready), 128'(1));
    check("rst_rd_ready", 128'(bus.rd_ready), 128'(0));
    check("rst_rd_valid", 128'(bus.rd_valid), 128'(0));
    check("rst_rd_data",  128'(bus.rd_data),  128'(0));
    check("rst_lane_err", 128'(bus.lane_err), 128'(0));
    check("rst_wr_drop",  128'(bus.wr_drop),  128'(0));

    // Fill and interleaved read
    fill(16'h0100);
    check("fill_rd_ready", 128'(bus.rd_ready), 128'(1));
    ix = '{7, 14, 21, 28, 3, 10, 17, 24};
    cycle(1'b0, 0, '0, 1'b0, 1'b1, pack_ix(), 1'b0);
    check("bad_bank_err", 128'(bus.lane_err), 128'(1));
    ix = '{8, 1, 26, 19, 12, 29, 6, 31};
    cycle(1'b0, 0, '0, 1'b0, 1'b1, pack_ix(), 1'b0);
    exp_lanes = '{16'h0108, 16'h0101, 16'h011A, 16'h0113, 16'h010C, 16'h011D, 16'h0106, 16'h011F};
    for (int i = 0; i < int'(Z); i++) exp_v[BW*i +: BW] = BW'(exp_lanes[i]);
    check("interleave_data", 128'(bus.rd_data), 128'(exp_v));
    check("interleave_valid", 128'(bus.rd_valid), 128'(1));
    check("err_sticky", 128'(bus.lane_err), 128'(1));

    // Ping-pong with both buffers full, then overflow attempt
    do_reset();
    fill(16'h0A00);
    fill(16'h0B00);
    check("full_wr_ready", 128'(bus.wr_ready), 128'(0));
    for (int i = 0; i < int'(Z); i++) wd[BW*i +: BW] = 16'hFFFF;
    cycle(1'b1, 1, wd, 1'b1, 1'b0, '0, 1'b0);
    check("ovf_drop", 128'(bus.wr_drop), 128'(1));
    check("ovf_still_full", 128'(bus.wr_ready), 128'(0));
    set_ix_identity();
    cycle(1'b0, 0, '0, 1'b0, 1'b1, pack_ix(), 1'b0);
    check("ping_lane5", 128'(bus.rd_data[BW*5 +: BW]), 128'(16'h0A05));
    cycle(1'b0, 0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("release_wr_ready", 128'(bus.wr_ready), 128'(1));
    cycle(1'b0, 0, '0, 1'b0, 1'b1, pack_ix(), 1'b0);
    check("pong_lane5", 128'(bus.rd_data[BW*5 +: BW]), 128'(16'h0B05));
    for (int i = 0; i < int'(Z); i++) ix[i] = 8 + i;
    cycle(1'b0, 0, '0, 1'b0, 1'b1, pack_ix(), 1'b0);
    check("ovf_no_write", 128'(bus.rd_data[BW*1 +: BW]), 128'(16'h0B09));

    // Simultaneous handoff and release with a read in the same cycle
    set_ix_identity();
    cycle(1'b0, 0, '0, 1'b1, 1'b1, pack_ix(), 1'b1);
    check("simul_old_rsel", 128'(bus.rd_data[BW*5 +: BW]), 128'(16'h0B05));
    check("simul_cnt_one", 128'({bus.rd_ready, bus.wr_ready}), 128'(2'b11));
    cycle(1'b0, 0, '0, 1'b0, 1'b1, pack_ix(), 1'b0);
    check("simul_rsel_toggled", 128'(bus.rd_data[BW*5 +: BW]), 128'(16'h0A05));

    // Asynchronous reset while rd_valid is high
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("areset_rd_valid", 128'(bus.rd_valid), 128'(0));
    check("areset_rd_data",  128'(bus.rd_data),  128'(0));
    check("areset_rd_ready", 128'(bus.rd_ready), 128'(0));
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 0, '0, 1'b0, 1'b1, pack_ix(), 1'b0);
    check("areset_no_read", 128'(bus.rd_valid), 128'(0));

    // Randomized traffic after both buffers are fully defined
    do_reset();
    fill(16'h1000);
    fill(16'h2000);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(Z); i++) begin
        if ($urandom_range(0, 19) == 0) ix[i] = int'($urandom_range(0, P - 1));
        else                            ix[i] = int'($urandom_range(0, 3)) * Z + i;
      end
      mip = pack_ix();
      wd  = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), wd,
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), mip,
            ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
